// File: rtl/updown_mod_counter.sv
// Modulo-MODULO up/down counter with step, enable, clear, load, terminal count and wrap pulse.
// Define UPDOWN_MOD_COUNTER_SATURATE_EN to clamp at the range ends instead of wrapping.
module updown_mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);
  // Truncated modulus: WIDTH-bit arithmetic is exact because wrapped results lie in 0..MODULO-1.
  localparam logic [WIDTH-1:0] MOD_LO = WIDTH'(MODULO);
  localparam logic [WIDTH-1:0] MAX    = WIDTH'(MODULO - 1);

  logic [WIDTH:0]   sum;
  logic             wrap_up;
  logic             wrap_dn;
  logic [WIDTH-1:0] nxt_up;
  logic [WIDTH-1:0] nxt_dn;
  logic [WIDTH-1:0] nxt_out;
  logic             nxt_ovf;

  assign sum     = {1'b0, out} + {1'b0, step};
  assign wrap_up = (sum >= MOD_W);
  assign wrap_dn = (out < step);

`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
  assign nxt_up = wrap_up ? MAX : sum[WIDTH-1:0];
  assign nxt_dn = wrap_dn ? '0  : out - step;
`else
  assign nxt_up = wrap_up ? out + step - MOD_LO : sum[WIDTH-1:0];
  assign nxt_dn = wrap_dn ? out + MOD_LO - step : out - step;
`endif

  always_comb begin
    nxt_out = out;
    nxt_ovf = 1'b0;
    if (clr) begin
      nxt_out = '0;
    end else if (load) begin
      nxt_out = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      nxt_out = up ? nxt_up : nxt_dn;
      nxt_ovf = up ? wrap_up : wrap_dn;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out <= '0;
      ovf <= 1'b0;
    end else begin
      out <= nxt_out;
      ovf <= nxt_ovf;
    end
  end

  assign tc = up ? (out == MAX) : (out == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Table-driven bench for updown_mod_counter (WIDTH=4, MODULO=10) with a scoreboard queue.
module tb_updown_mod_counter;

  typedef struct {
    logic       clr, load, en, up;
    logic [3:0] step, lv;
    logic [3:0] eout;
    logic       eovf, etc;
    string      name;
  } vec_t;

  logic       clk, rstn, en, up, clr, load;
  logic [3:0] step, load_val, out;
  logic       tc, ovf;

  int checks = 0;
  int passed = 0;

  vec_t vecs[$];
  vec_t sb[$];

  updown_mod_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .step(step), .clr(clr),
    .load(load), .load_val(load_val), .out(out), .tc(tc), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic c, input logic l, input logic e,
                              input logic u, input int s, input int lv, input int eo,
                              input logic eovf, input logic etc);
    vec_t v;
    v.name = name; v.clr = c; v.load = l; v.en = e; v.up = u;
    v.step = 4'(s); v.lv = 4'(lv); v.eout = 4'(eo); v.eovf = eovf; v.etc = etc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    clr = v.clr; load = v.load; en = v.en; up = v.up; step = v.step; load_val = v.lv;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".out"}, int'(out), int'(e.eout));
    chk({e.name, ".ovf"}, int'(ovf), int'(e.eovf));
    chk({e.name, ".tc"},  int'(tc),  int'(e.etc));
  endtask

  initial begin
    rstn = 1'b0; en = 0; up = 1; clr = 0; load = 0; step = 0; load_val = 0;

    // reset state and combinational tc
    #12;
    chk("rst.out", int'(out), 0);
    chk("rst.ovf", int'(ovf), 0);
    chk("rst.tc_up", int'(tc), 0);
    up = 1'b0; #1;
    chk("rst.tc_dn", int'(tc), 1);
    up = 1'b1;
    @(negedge clk); rstn = 1'b1;

`ifndef UPDOWN_MOD_COUNTER_SATURATE_EN
    for (int i = 1; i <= 10; i++)
      vecs.push_back(mk($sformatf("upwrap%0d", i), 0, 0, 1, 1, 1, 0, i % 10, i == 10, i == 9));
    vecs.push_back(mk("dn_load", 0, 1, 0, 0, 0, 2, 2, 0, 0));
    vecs.push_back(mk("dn9", 0, 0, 1, 0, 3, 0, 9, 1, 0));
    vecs.push_back(mk("dn6", 0, 0, 1, 0, 3, 0, 6, 0, 0));
    vecs.push_back(mk("dn3", 0, 0, 1, 0, 3, 0, 3, 0, 0));
    vecs.push_back(mk("dn0", 0, 0, 1, 0, 3, 0, 0, 0, 1));
    vecs.push_back(mk("dn7", 0, 0, 1, 0, 3, 0, 7, 1, 0));
    vecs.push_back(mk("ld8", 0, 1, 0, 1, 0, 8, 8, 0, 0));
    vecs.push_back(mk("up_wrap4", 0, 0, 1, 1, 4, 0, 2, 1, 0));
    vecs.push_back(mk("hold_clr_ovf", 0, 0, 0, 1, 4, 0, 2, 0, 0));
    vecs.push_back(mk("up_big9", 0, 0, 1, 1, 9, 0, 1, 1, 0));
`else
    vecs.push_back(mk("sat_ld8", 0, 1, 0, 1, 0, 8, 8, 0, 0));
    vecs.push_back(mk("sat_up1", 0, 0, 1, 1, 4, 0, 9, 1, 1));
    vecs.push_back(mk("sat_up2", 0, 0, 1, 1, 4, 0, 9, 1, 1));
    vecs.push_back(mk("sat_hold", 0, 0, 0, 1, 4, 0, 9, 0, 1));
    vecs.push_back(mk("sat_ld2", 0, 1, 0, 0, 0, 2, 2, 0, 0));
    vecs.push_back(mk("sat_dn1", 0, 0, 1, 0, 4, 0, 0, 1, 1));
    vecs.push_back(mk("sat_dn2", 0, 0, 1, 0, 4, 0, 0, 1, 1));
    vecs.push_back(mk("sat_dn_ok", 0, 1, 0, 0, 0, 7, 7, 0, 0));
    vecs.push_back(mk("sat_dn3", 0, 0, 1, 0, 3, 0, 4, 0, 0));
`endif
    vecs.push_back(mk("ld_clamp", 0, 1, 0, 1, 0, 12, 9, 0, 1));
    vecs.push_back(mk("clr_over_ld", 1, 1, 1, 1, 3, 5, 0, 0, 0));
    vecs.push_back(mk("ld_over_en", 0, 1, 1, 1, 3, 4, 4, 0, 0));
    vecs.push_back(mk("hold", 0, 0, 0, 1, 3, 0, 4, 0, 0));
    vecs.push_back(mk("step0", 0, 0, 1, 1, 0, 0, 4, 0, 0));
    vecs.push_back(mk("step0_dn", 0, 0, 1, 0, 0, 0, 4, 0, 0));
    vecs.push_back(mk("up5", 0, 0, 1, 1, 1, 0, 5, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset between edges at out=5
    @(negedge clk); en = 0; clr = 0; load = 0;
    #2 rstn = 1'b0;
    #1;
    chk("async.out", int'(out), 0);
    chk("async.ovf", int'(ovf), 0);
    @(negedge clk); rstn = 1'b1;
    apply(mk("resume1", 0, 0, 1, 1, 1, 0, 1, 0, 0));
    apply(mk("resume2", 0, 0, 1, 1, 1, 0, 2, 0, 0));

    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
